// File: rtl/decoder_scan_seq_pkg.sv
// Shared constants and types for the decoder select sequencer.
package decoder_scan_seq_pkg;

  localparam int unsigned SEL_W         = 2;
  localparam int unsigned DIV_W_DEFAULT = 8;

  localparam logic [SEL_W-1:0] LAST_SEL = 2'b11;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StRun  = ST_RUN
  } state_e;

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control and status bundle between the sequencer and its controller.
interface decoder_scan_seq_if
  import decoder_scan_seq_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
);

  logic             start;
  logic             stop;
  logic             mode;
  logic [DIV_W-1:0] div;
  logic [SEL_W-1:0] a;
  logic             busy;
  logic             step;
  logic             done;

  modport master (
    output start, stop, mode, div,
    input  a, busy, step, done
  );

  modport slave (
    input  start, stop, mode, div,
    output a, busy, step, done
  );

endinterface

// File: rtl/decoder_scan_seq_dwell_counter.sv
// Dwell counter: counts 0..limit, wrapping to 0 after flagging terminal count.
module dwell_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Select sequencer stepping the decoder code 00..11 with a programmable dwell,
// in wrapping or single-pass mode.
module decoder_scan_seq
  import decoder_scan_seq_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  decoder_scan_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] a_q, a_d;
  logic             busy_q, busy_d;
  logic             step_q, step_d;
  logic             done_q, done_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  // Holding the counter cleared while idle makes every accepted start begin at 0.
  assign cnt_clr = (state_q == StIdle) || bus.stop;
  assign cnt_en  = (state_q == StRun);

  dwell_counter #(
    .Width (DIV_W)
  ) u_dwell_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (div_q),
    .tc_o    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    div_d   = div_q;
    a_d     = a_q;
    busy_d  = busy_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        a_d    = '0;
        busy_d = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d = StRun;
          mode_d  = bus.mode;
          div_d   = bus.div;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          a_d     = '0;
        end else if (cnt_tc) begin
          if (a_q != LAST_SEL) begin
            a_d    = a_q + SEL_W'(1);
            step_d = 1'b1;
          end else if (!mode_q) begin
            a_d    = '0;
            step_d = 1'b1;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
            a_d     = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      div_q   <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.step = step_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed, table-driven bench for the decoder select sequencer.
module tb_decoder_scan_seq;

  logic clk;
  logic rst;

  decoder_scan_seq_if #(.DIV_W(8)) bus ();

  decoder_scan_seq #(
    .DIV_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] div;
    logic [1:0] a;
    logic       busy;
    logic       step;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void add(input logic st, input logic sp, input logic md,
                              input logic [7:0] dv, input logic [1:0] ea,
                              input logic eb, input logic es, input logic ed);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.div = dv;
    v.a = ea; v.busy = eb; v.step = es; v.done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Packed observation: {a, busy, step, done}
  function automatic logic [4:0] obs();
    return {bus.a, bus.busy, bus.step, bus.done};
  endfunction

  task automatic drive(input logic st, input logic sp, input logic md, input logic [7:0] dv);
    bus.start = st; bus.stop = sp; bus.mode = md; bus.div = dv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mism;
    int busy_cnt;
    int done_cnt;
    int done_idx;
    logic [1:0] ea;

    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    #2;

    // Reset dominates a held start
    tick(); check("rst_cyc1", 32'(obs()), 32'(5'b00_0_0_0));
    tick(); check("rst_cyc2", 32'(obs()), 32'(5'b00_0_0_0));
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    tick(); check("post_rst_idle", 32'(obs()), 32'(5'b00_0_0_0));

    // Single pass, mode=1, div=2
    add(1, 0, 1, 8'd2, 2'b00, 1, 0, 0);
    add(0, 0, 0, 8'd0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 8'd0, 2'b00, 1, 0, 0);
    for (int k = 1; k < 4; k++) begin
      add(0, 0, 0, 8'd0, 2'(k), 1, 1, 0);
      add(0, 0, 0, 8'd0, 2'(k), 1, 0, 0);
      add(0, 0, 0, 8'd0, 2'(k), 1, 0, 0);
    end
    add(0, 0, 0, 8'd0, 2'b00, 0, 0, 1);
    add(0, 0, 0, 8'd0, 2'b00, 0, 0, 0);

    // Continuous, div=0, then stop
    add(1, 0, 0, 8'd0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 8'd0, 2'b01, 1, 1, 0);
    add(0, 0, 0, 8'd0, 2'b10, 1, 1, 0);
    add(0, 0, 0, 8'd0, 2'b11, 1, 1, 0);
    add(0, 0, 0, 8'd0, 2'b00, 1, 1, 0);
    add(0, 0, 0, 8'd0, 2'b01, 1, 1, 0);
    add(0, 1, 0, 8'd0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 8'd0, 2'b00, 0, 0, 0);

    // Mid-run start/mode/div changes ignored
    add(1, 0, 1, 8'd1, 2'b00, 1, 0, 0);
    add(1, 0, 0, 8'd5, 2'b00, 1, 0, 0);
    add(1, 0, 0, 8'd5, 2'b01, 1, 1, 0);
    add(1, 0, 0, 8'd5, 2'b01, 1, 0, 0);
    add(1, 0, 0, 8'd5, 2'b10, 1, 1, 0);
    add(1, 0, 0, 8'd5, 2'b10, 1, 0, 0);
    add(1, 0, 0, 8'd5, 2'b11, 1, 1, 0);
    add(1, 0, 0, 8'd5, 2'b11, 1, 0, 0);
    add(1, 0, 0, 8'd5, 2'b00, 0, 0, 1);
    add(0, 0, 0, 8'd0, 2'b00, 0, 0, 0);

    // start+stop in idle stays idle
    add(1, 1, 0, 8'd0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 8'd0, 2'b00, 0, 0, 0);

    // stop on terminal count of a=11 in single pass: no done
    add(1, 0, 1, 8'd0, 2'b00, 1, 0, 0);
    add(0, 0, 0, 8'd0, 2'b01, 1, 1, 0);
    add(0, 0, 0, 8'd0, 2'b10, 1, 1, 0);
    add(0, 0, 0, 8'd0, 2'b11, 1, 1, 0);
    add(0, 1, 0, 8'd0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 8'd0, 2'b00, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].div);
      tick();
      check($sformatf("vec%0d", i), 32'(obs()),
            32'({vecs[i].a, vecs[i].busy, vecs[i].step, vecs[i].done}));
    end

    // Reset while a=10
    drive(1, 0, 0, 8'd0); tick();
    drive(0, 0, 0, 8'd0); tick(); tick();
    check("run_a_10", 32'(obs()), 32'(5'b10_1_1_0));
    rst = 1'b1;
    tick(); check("rst_mid_run", 32'(obs()), 32'(5'b00_0_0_0));
    rst = 1'b0;
    tick(); check("rst_mid_run_idle", 32'(obs()), 32'(5'b00_0_0_0));

    // Maximum dwell, single pass
    drive(1, 0, 1, 8'd255); tick();
    drive(0, 0, 0, 8'd0);
    mism = 0; busy_cnt = 0; done_cnt = 0; done_idx = -1;
    for (int i = 0; i < 1100; i++) begin
      if (i < 1024) begin
        ea = 2'(i / 256);
        if (obs() !== {ea, 1'b1, (i % 256 == 0) && (i > 0), 1'b0}) mism++;
      end else if (bus.busy !== 1'b0 || bus.a !== 2'b00) begin
        mism++;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_idx = i;
      end
      tick();
    end
    check("maxdwell_pattern_errs", 32'(mism), 32'd0);
    check("maxdwell_busy_cycles", 32'(busy_cnt), 32'd1024);
    check("maxdwell_done_count", 32'(done_cnt), 32'd1);
    check("maxdwell_done_cycle", 32'(done_idx), 32'd1024);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
Upstream select sequencer for the 2-to-4 decoder. Generates the 2-bit select code `a` that the decoder turns into one-hot d0..d3, stepping 00->01->10->11 with a programmable dwell time per code. Runs in either continuous (wrapping) or single-pass mode under start/stop control. Status pulses let downstream logic track each advance and the end of a single pass.

Parameters:
DIV_W, 8, width of the dwell divider and of the `div` port.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request to begin a sequence; sampled only in IDLE
stop   input   1      abort request; sampled in IDLE and RUN
mode   input   1      0 = continuous/wrapping, 1 = single pass; captured on accepted start
div    input   DIV_W  dwell minus one; each code is held div+1 cycles; captured on accepted start
a      output  2      select code to the decoder's `a` input
busy   output  1      sequence active; qualifies `a` for the decoder's consumer
step   output  1      one-cycle pulse in the first cycle `a` holds a newly advanced value
done   output  1      one-cycle pulse when a single pass completes

Behaviour:
- All outputs are registered. Reset (rst=1 at a clock edge) gives: state=IDLE, a=00, busy=0, step=0, done=0, dwell counter=0, captured mode/div=0. Reset wins over every other input.
- States:
  - IDLE: busy=0, a=00.
  - RUN: busy=1.
- IDLE -> RUN when start=1 and stop=0. At that edge:
  - mode_q<=mode, div_q<=div, cnt<=0;
  - a<=00, busy<=1, step<=0.
- IDLE with start=1 and stop=1: remain in IDLE (stop has priority).
- In RUN, each cycle:
  - If cnt != div_q: cnt<=cnt+1.
  - If cnt == div_q (terminal count): cnt<=0.
    - When a != 11: a<=a+1 and step<=1.
    - When a == 11 and mode_q=0: a<=00 (wrap) and step<=1.
    - When a == 11 and mode_q=1: RUN->IDLE; busy<=0, a<=00, done<=1, step<=0.
  - step and done are high for exactly one cycle and are otherwise 0.
- stop=1 in RUN: at the next edge go to IDLE with busy=0, a=00, cnt=0, and no done pulse. stop has priority over a simultaneous terminal count.
- start in RUN is ignored. mode and div changes during RUN are ignored; only the values captured at start are used.
- div=0: each code is held 1 cycle, so `a` advances every cycle.
- div=2^DIV_W-1: dwell is 2^DIV_W cycles. cnt is DIV_W bits wide and never overflows because it resets at terminal count.
- Single-pass timing: busy is high for exactly 4*(div+1) cycles, with 3 step pulses. done coincides with the first cycle of busy=0.
- Latency: accepted start to busy=1 and a=00 is 1 edge. Accepted stop to busy=0 is 1 edge.
- `a` is always a legal code, so the decoder output is always exactly one-hot.

Decomposition:
- Shared package holds:
  - SEL_W=2;
  - LAST_SEL=2'b11;
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1;
  - the default DIV_W.
- One natural sub-module is `dwell_counter`: a DIV_W-bit counter with clear, enable, and a terminal-count output for cnt == limit.
- The decoder itself is instantiated by the parent, not inside this block.

Test Plan:
1. rst=1 for 2 cycles with start=1 held -> a=00, busy=0, step=0, done=0 throughout; IDLE after release once start drops.
2. Single pass, mode=1, div=2, start pulse at edge 0:
   - a=00 for cycles 1-3, 01 for 4-6, 10 for 7-9, 11 for 10-12;
   - step high in cycles 4, 7, 10;
   - busy low and done=1 in cycle 13, then done=0.
3. Continuous, mode=0, div=0:
   - a sequence 00,01,10,11,00,01 on consecutive cycles, with step=1 from the second cycle on;
   - stop at cycle 6 -> next cycle busy=0, a=00, done stays 0.
4. Mid-run changes, running mode=1, div=1:
   - drive start=1, div=5, and mode=0 mid-run -> dwell stays 2 cycles, pass ends with done after 8 busy cycles, and no restart occurs.
5. Simultaneous events and reset:
   - start=1 and stop=1 together in IDLE -> stays idle;
   - stop asserted on the terminal-count cycle of a=11 with mode=1 -> IDLE with done=0;
   - rst=1 while a=10 -> reset values on the next edge.
6. Maximum dwell, div=255 (DIV_W=8), mode=1 -> each code held 256 cycles, busy high 1024 cycles, one done pulse, no counter wrap glitch.
